// File: rtl/link_ddr_pkg.sv
// Shared defaults and beat-state encoding for the DDR receive assembler.
package link_ddr_pkg;
   localparam int unsigned CH_WIDTH   = 16;
   localparam int unsigned NUM_CH     = 2;
   localparam int unsigned CORE_WIDTH = 2 * NUM_CH * CH_WIDTH;

   typedef enum logic {
      LO = 1'b0,
      HI = 1'b1
   } beat_state_e;
endpackage : link_ddr_pkg

// File: rtl/link_ddr_rx_assembler_if.sv
// Beat input, assembled-word output and status bundle of the receive assembler.
interface link_ddr_rx_assembler_if #(
   parameter int unsigned CH_WIDTH   = link_ddr_pkg::CH_WIDTH,
   parameter int unsigned NUM_CH     = link_ddr_pkg::NUM_CH,
   parameter int unsigned CORE_WIDTH = link_ddr_pkg::CORE_WIDTH
);
   logic [NUM_CH-1:0]          io_valid_i;
   logic [NUM_CH*CH_WIDTH-1:0] io_data_i;
   logic                       core_valid_o;
   logic [CORE_WIDTH-1:0]      core_data_o;
   logic                       core_yumi_i;
   logic [NUM_CH-1:0]          token_clk_o;
   logic                       overflow_o;
   logic                       skew_err_o;

   modport master (
      output io_valid_i, io_data_i, core_yumi_i,
      input  core_valid_o, core_data_o, token_clk_o, overflow_o, skew_err_o
   );

   modport slave (
      input  io_valid_i, io_data_i, core_yumi_i,
      output core_valid_o, core_data_o, token_clk_o, overflow_o, skew_err_o
   );
endinterface : link_ddr_rx_assembler_if

// File: rtl/link_ddr_rx_fifo.sv
// Word FIFO with registered head; a push into a full FIFO survives only alongside a pop.
module link_ddr_rx_fifo #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic             o_full,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_head
);
   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             r_valid;
   logic [WIDTH-1:0] r_head;

   logic             w_pop;
   logic             w_push;
   logic [AW:0]      w_count_nxt;
   logic [WIDTH-1:0] w_head_nxt;
   logic [AW-1:0]    w_rd_ptr_inc;

   assign w_pop        = i_pop && r_valid;
   assign w_push       = i_push && (!o_full || w_pop);
   assign w_rd_ptr_inc = AW'(r_rd_ptr + AW'(1));
   assign o_full       = (r_count == (AW+1)'(DEPTH));
   assign o_valid      = r_valid;
   assign o_head       = r_head;

   // Head register tracks the word that will be at the front after this edge.
   always_comb begin
      w_count_nxt = r_count;
      w_head_nxt  = r_head;
      if (w_push && !w_pop)
         w_count_nxt = (AW+1)'(r_count + (AW+1)'(1));
      else if (w_pop && !w_push)
         w_count_nxt = (AW+1)'(r_count - (AW+1)'(1));
      if (w_pop) begin
         if (r_count > (AW+1)'(1))
            w_head_nxt = r_mem[w_rd_ptr_inc];
         else if (w_push)
            w_head_nxt = i_data;
      end else if (w_push && !r_valid) begin
         w_head_nxt = i_data;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push)
         r_mem[r_wr_ptr] <= i_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_valid  <= 1'b0;
         r_head   <= '0;
      end else begin
         if (w_push) r_wr_ptr <= AW'(r_wr_ptr + AW'(1));
         if (w_pop)  r_rd_ptr <= w_rd_ptr_inc;
         r_count <= w_count_nxt;
         r_valid <= (w_count_nxt != '0);
         r_head  <= w_head_nxt;
      end
   end
endmodule : link_ddr_rx_fifo

// File: rtl/link_ddr_rx_assembler.sv
// Pairs two DDR channel beats into one core word, buffers it and returns decimated credit tokens.
module link_ddr_rx_assembler
   import link_ddr_pkg::*;
#(
   parameter int unsigned CH_WIDTH    = link_ddr_pkg::CH_WIDTH,
   parameter int unsigned NUM_CH      = link_ddr_pkg::NUM_CH,
   parameter int unsigned CORE_WIDTH  = link_ddr_pkg::CORE_WIDTH,
   parameter int unsigned FIFO_DEPTH  = 8,
   parameter int unsigned TOKEN_DECIM = 4
) (
   input  logic                     io_clk_i,
   input  logic                     io_link_reset_i,
   link_ddr_rx_assembler_if.slave   bus
);
   localparam int unsigned BEAT_W = NUM_CH * CH_WIDTH;
   localparam int unsigned PCW    = (TOKEN_DECIM > 1) ? $clog2(TOKEN_DECIM) : 1;

   beat_state_e         r_state;
   beat_state_e         w_state_nxt;
   logic [BEAT_W-1:0]   r_lo;
   logic [PCW-1:0]      r_pop_cnt;
   logic [NUM_CH-1:0]   r_token;
   logic                r_overflow;
   logic                r_skew;

   logic                w_beat;
   logic                w_idle;
   logic                w_skew_evt;
   logic                w_load_lo;
   logic                w_push;
   logic [CORE_WIDTH-1:0] w_word;
   logic                w_fifo_full;
   logic                w_fifo_valid;
   logic [CORE_WIDTH-1:0] w_fifo_head;
   logic                w_pop;
   logic                w_wrap;
   logic                w_drop;

   assign w_beat     = &bus.io_valid_i;
   assign w_idle     = ~|bus.io_valid_i;
   assign w_skew_evt = !w_beat && !w_idle;
   assign w_word     = CORE_WIDTH'({bus.io_data_i, r_lo});

   always_ff @(posedge io_clk_i or posedge io_link_reset_i) begin
      if (io_link_reset_i) r_state <= LO;
      else                 r_state <= w_state_nxt;
   end

   // A skew event abandons any half-built word regardless of state.
   always_comb begin
      w_state_nxt = r_state;
      if (w_skew_evt)
         w_state_nxt = LO;
      else if (w_beat)
         w_state_nxt = (r_state == LO) ? HI : LO;
   end

   always_comb begin
      w_load_lo = 1'b0;
      w_push    = 1'b0;
      if (w_beat) begin
         w_load_lo = (r_state == LO);
         w_push    = (r_state == HI);
      end
   end

   link_ddr_rx_fifo #(
      .WIDTH (CORE_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (io_clk_i),
      .rst     (io_link_reset_i),
      .i_push  (w_push),
      .i_data  (w_word),
      .i_pop   (bus.core_yumi_i),
      .o_full  (w_fifo_full),
      .o_valid (w_fifo_valid),
      .o_head  (w_fifo_head)
   );

   assign w_pop  = bus.core_yumi_i && w_fifo_valid;
   assign w_wrap = w_pop && (r_pop_cnt == PCW'(TOKEN_DECIM - 1));
   assign w_drop = w_push && w_fifo_full && !w_pop;

   always_ff @(posedge io_clk_i or posedge io_link_reset_i) begin
      if (io_link_reset_i) begin
         r_lo       <= '0;
         r_pop_cnt  <= '0;
         r_token    <= '0;
         r_overflow <= 1'b0;
         r_skew     <= 1'b0;
      end else begin
         if (w_skew_evt)     r_lo <= '0;
         else if (w_load_lo) r_lo <= bus.io_data_i;
         if (w_pop)
            r_pop_cnt <= w_wrap ? '0 : PCW'(r_pop_cnt + PCW'(1));
         if (w_wrap)     r_token    <= ~r_token;
         if (w_drop)     r_overflow <= 1'b1;
         if (w_skew_evt) r_skew     <= 1'b1;
      end
   end

   assign bus.core_valid_o = w_fifo_valid;
   assign bus.core_data_o  = w_fifo_head;
   assign bus.token_clk_o  = r_token;
   assign bus.overflow_o   = r_overflow;
   assign bus.skew_err_o   = r_skew;
endmodule : link_ddr_rx_assembler

// File: tb/tb_link_ddr_rx_assembler.sv
// Scoreboard bench: driver pushes expected words from a queue model, negedge monitor compares.
module tb_link_ddr_rx_assembler;
   localparam int DEPTH = 8;
   localparam int DECIM = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   link_ddr_rx_assembler_if bus ();

   link_ddr_rx_assembler dut (
      .io_clk_i        (clk),
      .io_link_reset_i (rst),
      .bus             (bus)
   );

   int checks   = 0;
   int failures = 0;

   // Reference model: pending half word, expected word queue, occupancy and flags.
   bit          have_lo;
   logic [31:0] lo_m;
   logic [63:0] exp_q[$];
   int          occ;
   int          pops;
   bit          ovf_m, skew_m;
   int          occ_now;
   bit          ovf_now, skew_now;
   logic [1:0]  tok_now;
   bit          mon_en = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      have_lo = 1'b0; lo_m = '0; exp_q.delete();
      occ = 0; pops = 0; ovf_m = 1'b0; skew_m = 1'b0;
   endtask

   task automatic cycle(input logic [1:0] v, input logic [31:0] d, input bit y);
      bit          pop;
      bit          push;
      logic [63:0] word;
      @(posedge clk);
      #1;
      bus.io_valid_i  = v;
      bus.io_data_i   = d;
      bus.core_yumi_i = y;
      occ_now  = occ;
      ovf_now  = ovf_m;
      skew_now = skew_m;
      tok_now  = (((pops / DECIM) % 2) == 1) ? 2'b11 : 2'b00;
      pop  = y && (occ > 0);
      push = 1'b0;
      word = '0;
      if (v == 2'b11) begin
         if (have_lo) begin
            word = {d, lo_m};
            push = 1'b1;
            have_lo = 1'b0;
         end else begin
            have_lo = 1'b1;
            lo_m = d;
         end
      end else if (v != 2'b00) begin
         skew_m = 1'b1;
         have_lo = 1'b0;
      end
      if (push) begin
         if (occ < DEPTH || pop) begin
            exp_q.push_back(word);
            occ++;
         end else begin
            ovf_m = 1'b1;
         end
      end
      if (pop) begin
         occ--;
         pops++;
      end
      mon_en = 1'b1;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      mon_en = 1'b0;
      rst = 1'b1;
      bus.io_valid_i  = 2'b11;
      bus.io_data_i   = $urandom;
      bus.core_yumi_i = 1'b0;
      #1;
      chk("rst_valid", 64'(bus.core_valid_o), 64'd0);
      chk("rst_data", bus.core_data_o, 64'd0);
      chk("rst_token", 64'(bus.token_clk_o), 64'd0);
      chk("rst_ovf", 64'(bus.overflow_o), 64'd0);
      chk("rst_skew", 64'(bus.skew_err_o), 64'd0);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      bus.io_valid_i = 2'b00;
      rst = 1'b0;
   endtask

   task automatic beat_pair(input logic [31:0] b0, input logic [31:0] b1, input bit y);
      cycle(2'b11, b0, y);
      cycle(2'b11, b1, y);
   endtask

   task automatic drain();
      for (int i = 0; i < 40 && occ > 0; i++) cycle(2'b00, '0, 1'b1);
      cycle(2'b00, '0, 1'b0);
      chk("drain_empty", 64'(exp_q.size()), 64'd0);
   endtask

   // Monitor compares every cycle the driver has stepped.
   initial begin
      forever begin
         @(negedge clk);
         if (mon_en && !rst) begin
            chk("valid", 64'(bus.core_valid_o), 64'(occ_now > 0));
            chk("token", 64'(bus.token_clk_o), 64'(tok_now));
            chk("overflow", 64'(bus.overflow_o), 64'(ovf_now));
            chk("skew", 64'(bus.skew_err_o), 64'(skew_now));
            if (bus.core_valid_o) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_word", 64'd1, 64'd0);
               end else begin
                  chk("head", bus.core_data_o, exp_q[0]);
                  if (bus.core_yumi_i) void'(exp_q.pop_front());
               end
            end
         end
      end
   end

   initial begin
      bus.io_valid_i  = '0;
      bus.io_data_i   = '0;
      bus.core_yumi_i = 1'b0;
      model_reset();
      do_reset();

      // Single word, visible one cycle after beat 1.
      beat_pair(32'h0000_1111, 32'h2222_3333, 1'b0);
      cycle(2'b00, '0, 1'b0);
      @(negedge clk);
      chk("single_word", bus.core_data_o, 64'h2222_3333_0000_1111);
      chk("single_valid", 64'(bus.core_valid_o), 64'd1);
      drain();

      // Gapped beats.
      cycle(2'b11, 32'hAAAA_0001, 1'b0);
      repeat (3) cycle(2'b00, '0, 1'b0);
      cycle(2'b11, 32'hBBBB_0002, 1'b0);
      cycle(2'b00, '0, 1'b0);
      @(negedge clk);
      chk("gap_word", bus.core_data_o, 64'hBBBB_0002_AAAA_0001);
      drain();

      // Token decimation over 8 back-to-back words with pops.
      do_reset();
      for (int i = 0; i < 8; i++) beat_pair(32'h100 + i, 32'h200 + i, 1'b1);
      drain();
      chk("token_pops", 64'(pops), 64'd8);
      chk("token_final", 64'(bus.token_clk_o), 64'd0);

      // Overflow: 9 words unpopped, then one more with a same-cycle pop.
      do_reset();
      for (int i = 0; i < 9; i++) beat_pair(32'hC000 + i, 32'hD000 + i, 1'b0);
      cycle(2'b00, '0, 1'b0);
      @(negedge clk);
      chk("ovf_flag", 64'(bus.overflow_o), 64'd1);
      chk("ovf_occ", 64'(occ), 64'd8);
      cycle(2'b11, 32'hE000_0000, 1'b0);
      cycle(2'b11, 32'hE000_0001, 1'b1);
      chk("ovf_full_pop_occ", 64'(occ), 64'd8);
      drain();

      // Skew in HI discards the partial word.
      do_reset();
      cycle(2'b11, 32'h5555_0000, 1'b0);
      cycle(2'b01, 32'h6666_0000, 1'b0);
      beat_pair(32'h7777_0001, 32'h8888_0002, 1'b0);
      cycle(2'b00, '0, 1'b0);
      @(negedge clk);
      chk("skew_flag", 64'(bus.skew_err_o), 64'd1);
      chk("skew_word", bus.core_data_o, 64'h8888_0002_7777_0001);
      drain();

      // Reset mid-word with three words buffered.
      for (int i = 0; i < 3; i++) beat_pair(32'h300 + i, 32'h400 + i, 1'b0);
      cycle(2'b11, 32'h9999_9999, 1'b0);
      do_reset();
      beat_pair(32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
      cycle(2'b00, '0, 1'b0);
      @(negedge clk);
      chk("post_rst_word", bus.core_data_o, 64'h9ABC_DEF0_1234_5678);
      drain();

      // Randomized traffic with occasional skew and reset.
      for (int blk = 0; blk < 4; blk++) begin
         do_reset();
         for (int i = 0; i < 600; i++) begin
            int unsigned r;
            logic [1:0]  v;
            r = $urandom_range(0, 99);
            if (r < 70)      v = 2'b11;
            else if (r < 98) v = 2'b00;
            else             v = (r[0]) ? 2'b01 : 2'b10;
            cycle(v, $urandom, ($urandom_range(0, 99) < (blk * 25 + 20)));
         end
         drain();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule : tb_link_ddr_rx_assembler
